// File: rtl/viterbi_req_sched.sv
// +--------------------------------------------------------------------------+
// | viterbi_req_sched: round-robin arbiter sharing one Viterbi decoder        |
// | among N_REQ channels; optional WAIT timeout via VITERBI_SCHED_TIMEOUT_EN. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module viterbi_req_sched #(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 256,
  parameter int TO_W        = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid_i,
  input  logic [16*N_REQ-1:0]   req_data_i,
  output logic [N_REQ-1:0]      req_ready_o,
  output logic                  dec_dvalid_o,
  output logic [15:0]           dec_data_o,
  input  logic [7:0]            dec_data_i,
  input  logic                  dec_valid_i,
  input  logic                  dec_busy_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [7:0]            res_data_o,
  output logic [ID_W-1:0]       res_id_o,
  output logic                  res_err_o,
  output logic                  sched_busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [15:0]     data_q, data_d;
  logic [7:0]      res_data_q, res_data_d;

`ifdef VITERBI_SCHED_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            res_err_q, res_err_d;
`else
  logic [TO_W-1:0] unused_timeout;
  assign unused_timeout = TO_W'(TIMEOUT_CYC);
`endif

  // Channels above last_grant win first; otherwise wrap to the lowest valid one.
  logic [N_REQ-1:0]           hi_mask;
  logic [N_REQ-1:0]           masked_req;
  logic [N_REQ-1:0]           pick_vec;
  logic [N_REQ-1:0]           grant_oh;
  logic [N_REQ:0][ID_W-1:0]   idx_chain;
  logic [N_REQ:0][15:0]       word_chain;
  logic [ID_W-1:0]            grant_idx;
  logic [15:0]                grant_word;
  logic                       can_grant;

  assign idx_chain[0]  = '0;
  assign word_chain[0] = '0;

  for (genvar k = 0; k < N_REQ; k++) begin : g_chan
    assign hi_mask[k]      = (ID_W'(k) > last_grant_q);
    assign idx_chain[k+1]  = idx_chain[k] | (grant_oh[k] ? ID_W'(k) : '0);
    assign word_chain[k+1] = word_chain[k] | (grant_oh[k] ? req_data_i[16*k +: 16] : 16'h0000);
  end

  assign masked_req = req_valid_i & hi_mask;
  assign pick_vec   = (|masked_req) ? masked_req : req_valid_i;
  assign grant_oh   = pick_vec & (~pick_vec + N_REQ'(1));
  assign grant_idx  = idx_chain[N_REQ];
  assign grant_word = word_chain[N_REQ];

  // rst_n gates the combinational ready so nothing transfers while held in reset.
  assign can_grant  = rst_n && (state_q == S_IDLE) && !dec_busy_i && (|req_valid_i);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    data_d       = data_q;
    res_data_d   = res_data_q;
`ifdef VITERBI_SCHED_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    res_err_d    = res_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (can_grant) begin
          data_d       = grant_word;
          id_d         = grant_idx;
          last_grant_d = grant_idx;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef VITERBI_SCHED_TIMEOUT_EN
        to_cnt_d = '0;
`endif
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (dec_valid_i) begin
          res_data_d = dec_data_i;
`ifdef VITERBI_SCHED_TIMEOUT_EN
          res_err_d  = 1'b0;
`endif
          state_d    = S_RESP;
        end
`ifdef VITERBI_SCHED_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          // The counter reaches TIMEOUT_CYC on this cycle: abort.
          to_cnt_d   = TO_W'(TIMEOUT_CYC);
          res_data_d = 8'h00;
          res_err_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          to_cnt_d   = to_cnt_q + TO_W'(1);
        end
`endif
      end
      S_RESP: begin
        if (res_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_W'(N_REQ - 1);
      id_q         <= '0;
      data_q       <= '0;
      res_data_q   <= '0;
`ifdef VITERBI_SCHED_TIMEOUT_EN
      to_cnt_q     <= '0;
      res_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      data_q       <= data_d;
      res_data_q   <= res_data_d;
`ifdef VITERBI_SCHED_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      res_err_q    <= res_err_d;
`endif
    end
  end

  assign req_ready_o  = can_grant ? grant_oh : '0;
  assign dec_dvalid_o = (state_q == S_ISSUE);
  assign dec_data_o   = data_q;
  assign res_valid_o  = (state_q == S_RESP);
  assign res_data_o   = res_data_q;
  assign res_id_o     = id_q;
  assign sched_busy_o = (state_q != S_IDLE);
`ifdef VITERBI_SCHED_TIMEOUT_EN
  assign res_err_o    = res_err_q;
`else
  assign res_err_o    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_viterbi_req_sched.sv
// +--------------------------------------------------------------------------+
// | tb_viterbi_req_sched: directed bench for viterbi_req_sched with a simple  |
// | behavioural decoder. Revision: 1.0                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_viterbi_req_sched;

  localparam int N_REQ       = 4;
  localparam int ID_W        = 2;
  localparam int TIMEOUT_CYC = 256;
  localparam int TO_W        = 9;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N_REQ-1:0]    req_valid_i;
  logic [16*N_REQ-1:0] req_data_i;
  logic [N_REQ-1:0]    req_ready_o;
  logic                dec_dvalid_o;
  logic [15:0]         dec_data_o;
  logic [7:0]          dec_data_i;
  logic                dec_valid_i;
  logic                dec_busy_i;
  logic                res_valid_o;
  logic                res_ready_i;
  logic [7:0]          res_data_o;
  logic [ID_W-1:0]     res_id_o;
  logic                res_err_o;
  logic                sched_busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  int         dec_lat    = 3;
  bit         use_fixed  = 1'b0;
  bit         dec_mute   = 1'b0;
  logic [7:0] fixed_byte = 8'h00;

  logic [15:0] words [N_REQ];

  always #5 clk = ~clk;

  viterbi_req_sched #(
    .N_REQ       (N_REQ),
    .ID_W        (ID_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_data_i   (req_data_i),
    .req_ready_o  (req_ready_o),
    .dec_dvalid_o (dec_dvalid_o),
    .dec_data_o   (dec_data_o),
    .dec_data_i   (dec_data_i),
    .dec_valid_i  (dec_valid_i),
    .dec_busy_i   (dec_busy_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_data_o   (res_data_o),
    .res_id_o     (res_id_o),
    .res_err_o    (res_err_o),
    .sched_busy_o (sched_busy_o)
  );

  function automatic logic [7:0] fold(input logic [15:0] w);
    return w[15:8] ^ w[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_dvalid(input string tag);
    int c;
    c = 0;
    while (!dec_dvalid_o && c < 64) begin
      @(negedge clk);
      c++;
    end
    check(tag, dec_dvalid_o, 1);
  endtask

  task automatic wait_res(input string tag);
    int c;
    c = 0;
    while (!res_valid_o && c < 100) begin
      @(negedge clk);
      c++;
    end
    check(tag, res_valid_o, 1);
  endtask

  // Decoder model: answers each issued word after dec_lat cycles with a 1-cycle pulse.
  initial begin
    logic [15:0] w;
    dec_valid_i = 1'b0;
    dec_data_i  = 8'h00;
    forever begin
      @(negedge clk);
      if (dec_dvalid_o === 1'b1 && !dec_mute) begin
        w = dec_data_o;
        repeat (dec_lat) @(negedge clk);
        dec_data_i  = use_fixed ? fixed_byte : fold(w);
        dec_valid_i = 1'b1;
        @(negedge clk);
        dec_valid_i = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int c;
    int ch;
    words[0] = 16'h1234;
    words[1] = 16'hA55A;
    words[2] = 16'h0F0F;
    words[3] = 16'hC3E1;

    rst_n       = 1'b0;
    res_ready_i = 1'b0;
    dec_busy_i  = 1'b0;
    req_valid_i = '1;
    for (int k = 0; k < N_REQ; k++) req_data_i[16*k +: 16] = words[k];

    repeat (3) @(negedge clk);
    check("rst_ready",   req_ready_o,  0);
    check("rst_dvalid",  dec_dvalid_o, 0);
    check("rst_rvalid",  res_valid_o,  0);
    check("rst_busy",    sched_busy_o, 0);
    check("rst_id",      res_id_o,     0);
    check("rst_data",    res_data_o,   0);
    check("rst_err",     res_err_o,    0);

    rst_n = 1'b1;
    #1;
    check("first_grant", req_ready_o, 4'b0001);

    // Round robin with every channel continuously valid.
    res_ready_i = 1'b1;
    for (int t = 0; t < 8; t++) begin
      ch = t % N_REQ;
      wait_dvalid("rr_issue");
      check("rr_word", dec_data_o, words[ch]);
      wait_res("rr_res");
      check("rr_id",   res_id_o,   ch);
      check("rr_data", res_data_o, fold(words[ch]));
      check("rr_err",  res_err_o,  0);
    end
    req_valid_i = '0;
    @(negedge clk);
    check("idle_busy",  sched_busy_o, 0);
    check("idle_ready", req_ready_o,  0);

    // Single request on ch2, slow decoder, result held by backpressure.
    use_fixed   = 1'b1;
    fixed_byte  = 8'h5A;
    dec_lat     = 20;
    res_ready_i = 1'b0;
    req_data_i[47:32] = 16'hB4C1;
    req_valid_i = 4'b0100;
    #1;
    check("single_ready", req_ready_o, 4'b0100);
    @(negedge clk);
    req_valid_i = '0;
    check("single_dvalid", dec_dvalid_o, 1);
    check("single_word",   dec_data_o,   16'hB4C1);
    @(negedge clk);
    check("single_pulse",  dec_dvalid_o, 0);
    wait_res("single_res");
    check("single_data", res_data_o, 8'h5A);
    check("single_id",   res_id_o,   2);
    check("single_err",  res_err_o,  0);

    req_valid_i = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_hold",
            {res_valid_o, res_data_o, res_id_o, res_err_o, req_ready_o, dec_dvalid_o, sched_busy_o},
            {1'b1, 8'h5A, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b1});
    end
    use_fixed   = 1'b0;
    dec_lat     = 2;
    res_ready_i = 1'b1;
    @(negedge clk);
    check("bp_regrant", req_ready_o,  4'b0001);
    check("bp_idle",    sched_busy_o, 0);
    @(negedge clk);
    req_valid_i = '0;
    check("bp_dvalid", dec_dvalid_o, 1);
    check("bp_word",   dec_data_o,   words[0]);
    wait_res("bp_res");
    check("bp_id",   res_id_o,   0);
    check("bp_data", res_data_o, fold(words[0]));

    // Decoder busy blocks any grant; release grants ch1 in that same cycle.
    dec_busy_i  = 1'b1;
    req_valid_i = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("busy_gate", {req_ready_o, dec_dvalid_o, sched_busy_o}, 0);
    end
    dec_busy_i = 1'b0;
    #1;
    check("busy_release", req_ready_o, 4'b0010);
    @(negedge clk);
    req_valid_i = '0;
    check("busy_dvalid", dec_dvalid_o, 1);
    check("busy_word",   dec_data_o,   words[1]);
    wait_res("busy_res");
    check("busy_id",   res_id_o,   1);
    check("busy_data", res_data_o, fold(words[1]));

    dec_mute = 1'b1;
`ifdef VITERBI_SCHED_TIMEOUT_EN
    req_valid_i = 4'b1000;
    wait_dvalid("to_issue");
    req_valid_i = '0;
    c = 0;
    while (!res_valid_o && c < 400) begin
      @(negedge clk);
      c++;
    end
    check("to_cycles", c,          TIMEOUT_CYC + 1);
    check("to_err",    res_err_o,  1);
    check("to_data",   res_data_o, 8'h00);
    check("to_id",     res_id_o,   3);
`endif

    // Silent decoder then reset while waiting.
    req_valid_i = 4'b1000;
    wait_dvalid("hang_issue");
    req_valid_i = '0;
    repeat (50) @(negedge clk);
    check("hang_busy",   sched_busy_o, 1);
    check("hang_rvalid", res_valid_o,  0);
    rst_n = 1'b0;
    #1;
    check("midrst_busy",   sched_busy_o, 0);
    check("midrst_rvalid", res_valid_o,  0);
    check("midrst_id",     res_id_o,     0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
